// File: rtl/clk_rate_sched_if.sv
// ---------------------------------------------------------------------------
// clk_rate_sched_if
//   Four-phase configuration port of the clock-tree rate scheduler.
//
//   req  requester -> scheduler  request, held until ack rises
//   ch   requester -> scheduler  target channel index
//   sel  requester -> scheduler  rate select, divide ratio 2^(sel+1)
//   en   requester -> scheduler  channel enable
//   ack  scheduler -> requester  acknowledge, held until req drops
//   err  scheduler -> requester  valid with ack; channel index out of range
// ---------------------------------------------------------------------------
interface clk_rate_sched_if;
  logic       req;
  logic [3:0] ch;
  logic [3:0] sel;
  logic       en;
  logic       ack;
  logic       err;

  modport master (output req, ch, sel, en, input ack, err);
  modport slave  (input req, ch, sel, en, output ack, err);
endinterface

// File: rtl/clk_rate_sched.sv
// ---------------------------------------------------------------------------
// clk_rate_sched
//   Synchronous rate scheduler running on the clock-tree base clock. Each of
//   NCH channels gets a one-cycle enable pulse every 2^(sel+1) cycles, aligned
//   to a free-running 16-bit timebase. Rate/enable updates come in over a
//   four-phase handshake and take effect only on the target channel's own
//   period boundary, so a running consumer never sees a shortened period.
//
//   clk     in   base clock, rising edge
//   rstb    in   asynchronous active-low reset
//   cfg     if   configuration handshake (slave side)
//   en_out  out  per-channel registered enable pulses
//   cnt     out  free-running timebase
//
//   state | meaning
//   IDLE  | waiting for cfg.req; latches the request fields when it arrives
//   WAIT  | request latched; waiting for the target's period boundary
//   ACK   | ack (and err) driven; waiting for cfg.req to drop
// ---------------------------------------------------------------------------
module clk_rate_sched #(
  parameter int NCH = 8
) (
  input  logic                clk,
  input  logic                rstb,
  clk_rate_sched_if.slave     cfg,
  output logic [NCH-1:0]      en_out,
  output logic [15:0]         cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t         state;
  logic [3:0]     p_ch;
  logic [3:0]     p_sel;
  logic           p_en;
  logic           ack_q;
  logic           err_q;

  logic [3:0]     sel_r [NCH];
  logic [NCH-1:0] en_r;

  logic [15:0]    cnt_nxt;
  logic           tgt_valid;
  logic           tgt_en;
  logic [3:0]     tgt_sel;
  logic           apply;
  logic [3:0]     sel_nxt [NCH];
  logic [NCH-1:0] en_nxt;
  logic [NCH-1:0] pulse_nxt;

  // Low (sel+1) bits set: a count is on a period boundary when these are 0.
  function automatic logic [15:0] period_mask(input logic [3:0] sel);
    return 16'hFFFF >> (4'd15 - sel);
  endfunction

  assign cnt_nxt = cnt + 16'd1;
  assign cfg.ack = ack_q;
  assign cfg.err = err_q;

  // Current settings of the pending target. Compare rather than index so an
  // out-of-range channel number never addresses past the array.
  always_comb begin
    tgt_en  = 1'b0;
    tgt_sel = 4'd0;
    for (int c = 0; c < NCH; c++) begin
      if (p_ch == 4'(c)) begin
        tgt_en  = en_r[c];
        tgt_sel = sel_r[c];
      end
    end
  end

  assign tgt_valid = ({1'b0, p_ch} < 5'(NCH));

  // A disabled channel has no period to protect, so it updates immediately;
  // a running one waits until the upcoming count closes its old period.
  assign apply = (state == WAIT) && tgt_valid &&
                 (!tgt_en || ((cnt_nxt & period_mask(tgt_sel)) == 16'd0));

  // Post-edge channel settings; the pulse on the apply edge already follows
  // the new values, which is what suppresses the boundary pulse on disable.
  always_comb begin
    en_nxt    = en_r;
    pulse_nxt = '0;
    for (int c = 0; c < NCH; c++) begin
      sel_nxt[c] = sel_r[c];
      if (apply && (p_ch == 4'(c))) begin
        sel_nxt[c] = p_sel;
        en_nxt[c]  = p_en;
      end
      pulse_nxt[c] = en_nxt[c] &&
                     ((cnt_nxt & period_mask(sel_nxt[c])) == 16'd0);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt    <= 16'd0;
      en_r   <= '0;
      en_out <= '0;
      for (int c = 0; c < NCH; c++) begin
        sel_r[c] <= 4'd0;
      end
    end else begin
      cnt    <= cnt_nxt;
      en_r   <= en_nxt;
      en_out <= pulse_nxt;
      for (int c = 0; c < NCH; c++) begin
        sel_r[c] <= sel_nxt[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      p_ch  <= 4'd0;
      p_sel <= 4'd0;
      p_en  <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg.req) begin
            p_ch  <= cfg.ch;
            p_sel <= cfg.sel;
            p_en  <= cfg.en;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!tgt_valid) begin
            err_q <= 1'b1;
            ack_q <= 1'b1;
            state <= ACK;
          end else if (apply) begin
            ack_q <= 1'b1;
            state <= ACK;
          end
        end
        ACK: begin
          if (!cfg.req) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_rate_sched.sv
module tb_clk_rate_sched;
  localparam int NCH = 8;

  logic           clk = 1'b0;
  logic           rstb = 1'b0;
  logic [NCH-1:0] en_out;
  logic [15:0]    cnt;

  clk_rate_sched_if cfg_if();

  clk_rate_sched #(.NCH(NCH)) dut (
    .clk    (clk),
    .rstb   (rstb),
    .cfg    (cfg_if.slave),
    .en_out (en_out),
    .cnt    (cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: time is an edge counter; a request's apply edge is
  // computed arithmetically at acceptance from the spec's boundary rule.
  int             m_cnt = 0;
  int             edge_n = 0;
  int             apply_edge = 0;
  int             phase = 0;       // 0 idle, 1 pending, 2 acknowledged
  int             q_ch = 0, q_sel = 0, q_en = 0;
  int             m_sel [16];
  bit             m_en [16];
  bit             m_ack = 1'b0;
  bit             m_err = 1'b0;
  logic [NCH-1:0] m_exp = '0;
  int             p0 = 0, p1 = 0;

  initial begin
    for (int c = 0; c < 16; c++) begin
      m_sel[c] = 0;
      m_en[c]  = 1'b0;
    end
    forever begin
      @(posedge clk or negedge rstb);
      if (!rstb) begin
        m_cnt = 0; edge_n = 0; phase = 0; m_ack = 1'b0; m_err = 1'b0; m_exp = '0;
        for (int c = 0; c < 16; c++) begin
          m_sel[c] = 0;
          m_en[c]  = 1'b0;
        end
      end else begin
        int d;
        edge_n++;
        m_cnt = (m_cnt + 1) % 65536;
        case (phase)
          0: if (cfg_if.req === 1'b1) begin
               q_ch = int'(cfg_if.ch); q_sel = int'(cfg_if.sel); q_en = int'(cfg_if.en);
               phase = 1;
               if (q_ch >= NCH || !m_en[q_ch]) apply_edge = edge_n + 1;
               else begin
                 d = 2 << m_sel[q_ch];
                 apply_edge = edge_n + d - (m_cnt % d);
               end
             end
          1: if (edge_n == apply_edge) begin
               if (q_ch < NCH) begin
                 m_sel[q_ch] = q_sel;
                 m_en[q_ch]  = (q_en != 0);
                 m_err = 1'b0;
               end else m_err = 1'b1;
               m_ack = 1'b1;
               phase = 2;
             end
          default: if (cfg_if.req === 1'b0) begin
               m_ack = 1'b0; m_err = 1'b0; phase = 0;
             end
        endcase
        for (int c = 0; c < NCH; c++)
          m_exp[c] = m_en[c] && ((m_cnt % (2 << m_sel[c])) == 0);
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (en_out !== m_exp || cnt !== 16'(m_cnt) || cfg_if.ack !== m_ack || cfg_if.err !== m_err) begin
        errors++;
        if (errors < 20)
          $display("FAIL cycle_cmp t=%0t en_out=%h exp=%h cnt=%0d exp=%0d ack=%b exp=%b err=%b exp=%b",
                   $time, en_out, m_exp, cnt, m_cnt, cfg_if.ack, m_ack, cfg_if.err, m_err);
      end
      if (en_out[0] === 1'b1) p0++;
      if (en_out[1] === 1'b1) p1++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One full four-phase transaction. acc_cnt: cnt at the accepting edge;
  // lat: edges from acceptance to ack; ack_cnt: cnt when ack is first seen.
  task automatic cfg(input int ch, input int sel, input int en,
                     output int acc_cnt, output int ack_cnt, output int lat, output int err);
    bit got = 1'b0;
    @(negedge clk);
    cfg_if.ch  = 4'(ch);
    cfg_if.sel = 4'(sel);
    cfg_if.en  = (en != 0);
    cfg_if.req = 1'b1;
    @(negedge clk);
    acc_cnt = int'(cnt);
    lat = 0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      lat++;
      if (cfg_if.ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    ack_cnt = int'(cnt);
    err = int'(cfg_if.err);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout: got ack=%b expected 1 (ch %0d)", cfg_if.ack, ch);
    end
    cfg_if.req = 1'b0;
    @(negedge clk);
    chk("ack_fall", int'(cfg_if.ack) + int'(cfg_if.err), 0);
  endtask

  task automatic wait_pulse(input int ch, input int budget, output int pc);
    pc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (((en_out >> ch) & 1) == 1) begin
        pc = int'(cnt);
        break;
      end
    end
  endtask

  initial begin
    int a, k, l, e, pc, pc2, q, guard, iter, r, rch;
    cfg_if.req = 1'b0; cfg_if.ch = 4'd0; cfg_if.sel = 4'd0; cfg_if.en = 1'b0;
    rstb = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_ack", int'(cfg_if.ack), 0);
    chk("rst_en_out", int'(en_out), 0);
    rstb = 1'b1;
    @(negedge clk);
    chk("first_cnt", int'(cnt), 1);

    // Abort while a ch1 request is pending.
    @(negedge clk);
    cfg_if.ch = 4'd1; cfg_if.sel = 4'd4; cfg_if.en = 1'b1; cfg_if.req = 1'b1;
    @(posedge clk);
    #1 rstb = 1'b0;
    #1;
    chk("abort_cnt", int'(cnt), 0);
    chk("abort_ack", int'(cfg_if.ack), 0);
    chk("abort_en_out", int'(en_out), 0);
    cfg_if.req = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    q = 0;
    repeat (40) begin
      @(negedge clk);
      if (en_out[1] === 1'b1) q++;
    end
    chk("ch1_quiet", q, 0);
    cfg(3, 1, 1, a, k, l, e);
    chk("reaccept_lat", l, 1);

    // Wrap channels: enabled early, sel=15.
    cfg(0, 15, 1, a, k, l, e);
    cfg(1, 15, 1, a, k, l, e);

    // Disabled ch2 -> applied next edge, period 8.
    cfg(2, 2, 1, a, k, l, e);
    chk("t1_lat", l, 1);
    chk("t1_err", e, 0);
    wait_pulse(2, 20, pc);
    chk("t1_phase", pc % 8, 0);
    wait_pulse(2, 20, pc2);
    chk("t1_period", pc2 - pc, 8);

    // Running ch2 sel=2 -> sel=0, accepted at cnt%8==3.
    guard = 0;
    while (m_cnt % 8 != 1 && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    cfg(2, 0, 1, a, k, l, e);
    chk("t2_acc", a % 8, 3);
    chk("t2_apply", k % 8, 0);
    chk("t2_lat", l, 5);
    wait_pulse(2, 8, pc);
    chk("t2_rate", pc % 2, 0);

    // Ch5 sel=0 -> sel=3.
    cfg(5, 0, 1, a, k, l, e);
    chk("t3_lat0", l, 1);
    repeat (3) @(negedge clk);
    cfg(5, 3, 1, a, k, l, e);
    chk("t3_lat_le2", int'(l <= 2), 1);
    chk("t3_even", k % 2, 0);
    wait_pulse(5, 40, pc);
    chk("t3_phase16", pc % 16, 0);

    // Out-of-range channel.
    cfg(9, 3, 1, a, k, l, e);
    chk("t4_err", e, 1);
    chk("t4_lat", l, 1);

    // Random traffic on channels 2..7 and invalid indices up to the wrap.
    iter = 0;
    while (m_cnt < 65000 && iter < 30000) begin
      repeat ($urandom_range(0, 8)) @(negedge clk);
      r   = int'($urandom_range(0, 9));
      rch = (r < 8) ? int'($urandom_range(2, 7)) : int'($urandom_range(8, 15));
      cfg(rch, int'($urandom_range(0, 6)), int'($urandom_range(0, 3) != 0), a, k, l, e);
      chk("rnd_err", e, int'(rch >= NCH));
      iter++;
    end

    // Disable ch0 before the wrap: applied at cnt=0 with that pulse suppressed.
    cfg(0, 15, 0, a, k, l, e);
    chk("wrap_apply_cnt", k, 0);
    repeat (8) @(negedge clk);
    chk("wrap_ch0_pulses", p0, 0);
    chk("wrap_ch1_pulses", p1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_rate_sched.md
# clk_rate_sched

Synchronous rate scheduler for the clock tree. It runs on the tree's base clock and replaces direct use of the ripple-divided clocks by downstream channels. For each of NCH consumer channels it generates a one-cycle clock-enable pulse at fclk/2^(sel+1), matching tree taps f_out[1]..f_out[16]. Per-channel rate/enable updates arrive over a four-phase request/acknowledge port and are applied only on the channel's own period boundary, so no consumer ever sees a truncated period.

## Interface
- NCH, 8: number of consumer channels, 1..16.
- clk  in  1  base clock (tree f_out[0]); all logic on rising edge.
- rstb  in  1  reset, asynchronous, active-low.
- cfg_req  in  1  configuration request, four-phase.
- cfg_ch  in  4  target channel index.
- cfg_sel  in  4  rate select; divide ratio D = 2^(cfg_sel+1), range 2..65536.
- cfg_en  in  1  channel enable.
- cfg_ack  out  1  configuration acknowledge.
- cfg_err  out  1  valid with cfg_ack; 1 = cfg_ch >= NCH, request ignored.
- en_out  out  NCH  per-channel one-cycle enable pulses (registered).
- cnt  out  16  free-running timebase.

## Operation
- Timebase: cnt increments by 1 every edge and wraps 0xFFFF->0x0000.
- Per-channel state: sel_r[c] (4b) and en_r[c] (1b).
- Pulses: en_out[c] = 1 in exactly the cycles where en_r[c]=1 and cnt[sel_r[c]:0] == 0.
  - Registered output: computed at each edge from cnt+1 and the post-edge sel_r/en_r.
- Handshake FSM, states IDLE, WAIT, ACK:
  - IDLE: cfg_req=1 at an edge latches cfg_ch/cfg_sel/cfg_en into pending registers and goes to WAIT. The requester must hold the fields stable until that edge.
  - WAIT, cfg_ch >= NCH: apply nothing; next edge sets err=1, goes to ACK.
  - WAIT, target disabled (en_r=0): apply at the next edge.
  - WAIT, target enabled: apply at the first edge where (cnt+1)[old sel_r:0] == 0, i.e. the next old-period boundary.
  - On apply: sel_r/en_r are written and en_out for that edge uses the new values. Go to ACK.
  - ACK: cfg_ack=1 (and cfg_err as set). Stay until cfg_req is sampled 0, then cfg_ack=0, cfg_err=0, go to IDLE.
- Only one request is outstanding at a time; cfg_req is ignored outside IDLE.
- Rate-change guarantee: the interval between consecutive en_out[c] pulses is never less than min(old D, new D).
- Disable: applied at the boundary; the pulse at that boundary is suppressed.
- Re-enable: the first pulse occurs at the next cnt multiple of the new D.

## Timing
- Reset values: cnt=0, en_r=0, sel_r=0, en_out=0, cfg_ack=0, cfg_err=0, FSM=IDLE. Any pending request is discarded.
- The first edge after rstb deasserts gives cnt=1.
- Request latency, req sampled at edge n:
  - Disabled target: applied at edge n+1; cfg_ack high after n+1.
  - Enabled target: applied at the first boundary edge at or after n+1, at most n+D_old; cfg_ack rises at that apply edge.
- After req drops, cfg_ack falls one edge later. The earliest re-accept is the edge after that.
- rstb low in WAIT or ACK: immediate abort; cfg_ack drops asynchronously.
- Wrap-around: sel=15 pulses only when cnt=0, every 65536 cycles. All channels with any sel pulse when cnt=0.

## Test plan
- Reset, then cfg ch2 sel=2 en=1 (channel disabled) -> ack one edge after acceptance; en_out[2] pulses when cnt%8==0, period 8; other bits stay 0.
- Ch2 running at sel=2, request sel=0 with cnt=3 at acceptance -> apply when cnt becomes 8, ack then; pulses at 8,10,12,...; no gap below 2 and no pulse before 8.
- Ch5 at sel=0, request sel=3 -> apply at the next even cnt; next pulse at the next multiple of 16; gap >= 2.
- cfg_ch=9 with NCH=8 -> cfg_ack=1 with cfg_err=1; no en_r/sel_r change. Drop req -> ack and err fall on the next edge.
- Ch0 sel=15 en=1 -> exactly one pulse per 65536 cycles at cnt=0 across two wraps. Disable request -> applied at cnt=0, that pulse suppressed.
- Assert rstb low while in WAIT with ch1 pending -> outputs return to reset values immediately; after release ch1 stays disabled and FSM accepts a new request.
